// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI request arbiter and related
// shared-bus controllers.
//   state_t : sequencer states
//   idx_w() : index width for an N-entry arbiter (never below 1 bit)
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } state_t;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_TIMEOUT = 1023;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index where the search starts (highest priority this round)
//   grant : one-hot winner, all zero when nothing is requested
//   idx   : binary index of the winner (0 when nothing is requested)
module rr_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]           req,
  input  logic [idx_w(N)-1:0]    ptr,
  output logic [N-1:0]           grant,
  output logic [idx_w(N)-1:0]    idx
);

  localparam int unsigned W = idx_w(N);

  logic        found;
  int unsigned pos;

  // Scan N positions starting at ptr, wrapping; first set bit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (32'(ptr) + i) % N;
      if (!found && req[W'(pos)]) begin
        found            = 1'b1;
        grant[W'(pos)]   = 1'b1;
        idx              = W'(pos);
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Shares one SPI master engine among NUM_REQ requesters: round-robin grant,
// one start pulse per transaction, watchdog abort, one-cycle ack to winner.
//   clk, reset         : clock, synchronous active-high reset
//   req, req_data      : per-requester level request and TX word
//   ack, rsp_data,
//   rsp_err            : one-hot completion pulse with RX word / timeout flag
//   eng_start, eng_tx,
//   eng_abort          : engine control (start pulse, TX word, abort pulse)
//   eng_done, eng_rx   : engine completion pulse and RX word
//   busy, gnt_id       : sequencer not idle, current/most recent winner
module spi_req_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          ack,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        eng_start,
  output logic [DATA_W-1:0]           eng_tx,
  output logic                        eng_abort,
  input  logic                        eng_done,
  input  logic [DATA_W-1:0]           eng_rx,
  output logic                        busy,
  output logic [idx_w(NUM_REQ)-1:0]   gnt_id
);

  localparam int unsigned GW       = idx_w(NUM_REQ);
  localparam int unsigned CW       = 16;
  localparam int unsigned LAST     = TIMEOUT - 1;
  localparam int unsigned PRE_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
  localparam bit          EARLY_ABORT = (TIMEOUT == 1);

  state_t               state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [GW-1:0]        rr_ptr, rr_d;
  logic [NUM_REQ-1:0]   arb_grant;
  logic [GW-1:0]        arb_idx;
  logic [DATA_W-1:0]    sel_data;

  logic [NUM_REQ-1:0]   ack_d;
  logic [DATA_W-1:0]    rsp_data_d, tx_d;
  logic                 rsp_err_d, start_d, abort_d, busy_d;
  logic [GW-1:0]        gnt_d;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // TX word of the arbiter's current pick.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == GW'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Next state and next values of every registered output.
  // The abort is decided one cycle ahead so it is visible in the final
  // WAIT_DONE cycle; a done arriving in the deciding cycle suppresses it.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    rr_d       = rr_ptr;
    ack_d      = '0;
    start_d    = 1'b0;
    abort_d    = 1'b0;
    tx_d       = eng_tx;
    gnt_d      = gnt_id;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    unique case (state)
      IDLE: begin
        if (|arb_grant) begin
          state_d = START;
          gnt_d   = arb_idx;
          tx_d    = sel_data;
          start_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
        abort_d = EARLY_ABORT;
      end
      WAIT_DONE: begin
        cnt_d = cnt + CW'(1);
        if (cnt == CW'(LAST)) begin
          // abort already issued; a late done cannot undo it
          state_d    = ACK;
          ack_d      = NUM_REQ'(1) << gnt_id;
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
        end else if (eng_done) begin
          state_d    = ACK;
          ack_d      = NUM_REQ'(1) << gnt_id;
          rsp_data_d = eng_rx;
          rsp_err_d  = 1'b0;
        end else if (cnt == CW'(PRE_LAST)) begin
          abort_d = 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        rr_d    = (gnt_id == GW'(NUM_REQ - 1)) ? '0 : gnt_id + GW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter, pointer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      ack       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      eng_start <= 1'b0;
      eng_tx    <= '0;
      eng_abort <= 1'b0;
      busy      <= 1'b0;
      gnt_id    <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rr_ptr    <= rr_d;
      ack       <= ack_d;
      rsp_data  <= rsp_data_d;
      rsp_err   <= rsp_err_d;
      eng_start <= start_d;
      eng_tx    <= tx_d;
      eng_abort <= abort_d;
      busy      <= busy_d;
      gnt_id    <= gnt_d;
    end
  end

endmodule
